// File: rtl/craps_round_ctrl_pkg.sv
// Shared types and dice constants for the craps round controller.
package craps_pkg;

  typedef enum logic [1:0] {
    ST_COME_OUT = 2'b00,
    ST_POINT    = 2'b01,
    ST_WIN      = 2'b10,
    ST_LOSE     = 2'b11
  } state_t;

  localparam int unsigned SUM_MIN    = 2;
  localparam int unsigned SUM_MAX    = 12;
  localparam int unsigned NATURAL_7  = 7;
  localparam int unsigned NATURAL_11 = 11;
  localparam int unsigned CRAPS_2    = 2;
  localparam int unsigned CRAPS_3    = 3;
  localparam int unsigned CRAPS_12   = 12;

endpackage

// File: rtl/craps_round_ctrl_if.sv
// Roll/ack handshake and status bus between host and craps_round_ctrl.
interface craps_round_ctrl_if
  import craps_pkg::*;
#(
  parameter int unsigned SUM_W  = 4,
  parameter int unsigned ROLL_W = 6,
  parameter int unsigned CNT_W  = 8
);
  logic              roll_valid;
  logic [SUM_W-1:0]  sum;
  logic              new_game;
  state_t            state;
  logic [SUM_W-1:0]  point;
  logic [ROLL_W-1:0] rolls;
  logic              bad_sum;
  logic [CNT_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  loss_cnt;

  modport master (
    output roll_valid, sum, new_game,
    input  state, point, rolls, bad_sum, win_cnt, loss_cnt
  );

  modport slave (
    input  roll_valid, sum, new_game,
    output state, point, rolls, bad_sum, win_cnt, loss_cnt
  );
endinterface

// File: rtl/craps_round_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and sync clear.
module craps_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset || i_clr)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))
      r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/craps_round_ctrl.sv
// Craps round controller: latches point, holds verdict until new_game.
// Win/loss statistics counters are built only when CRAPS_STATS_EN is defined.
module craps_round_ctrl
  import craps_pkg::*;
#(
  parameter int unsigned SUM_W     = 4,
  parameter int unsigned ROLL_W    = 6,
  parameter int unsigned MAX_ROLLS = 0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  craps_round_ctrl_if.slave bus
);
  state_t            r_state, w_next;
  logic [SUM_W-1:0]  r_point;
  logic              r_bad;
  logic              w_bad, w_roll_inc, w_clr, w_set_point;
  logic [ROLL_W-1:0] w_rolls;
  logic [31:0]       w_sum32, w_pt_rolls;
  logic              w_legal, w_limit;

  assign w_sum32 = 32'(bus.sum);
  assign w_legal = (w_sum32 >= SUM_MIN) && (w_sum32 <= SUM_MAX);

  // Current rolls equals the point-phase count after this roll's increment,
  // except once saturated, where the increment no longer happens.
  assign w_pt_rolls = (w_rolls == '1) ? (32'(w_rolls) - 32'd1) : 32'(w_rolls);
  assign w_limit    = (MAX_ROLLS != 0) && (w_pt_rolls == MAX_ROLLS);

  always_comb begin
    w_next      = r_state;
    w_bad       = 1'b0;
    w_roll_inc  = 1'b0;
    w_clr       = 1'b0;
    w_set_point = 1'b0;
    case (r_state)
      ST_COME_OUT: begin
        if (bus.roll_valid) begin
          if (!w_legal) begin
            w_bad = 1'b1;
          end else begin
            w_roll_inc = 1'b1;
            if (w_sum32 == NATURAL_7 || w_sum32 == NATURAL_11)
              w_next = ST_WIN;
            else if (w_sum32 == CRAPS_2 || w_sum32 == CRAPS_3 || w_sum32 == CRAPS_12)
              w_next = ST_LOSE;
            else begin
              w_next      = ST_POINT;
              w_set_point = 1'b1;
            end
          end
        end
      end
      ST_POINT: begin
        if (bus.roll_valid) begin
          if (!w_legal) begin
            w_bad = 1'b1;
          end else begin
            w_roll_inc = 1'b1;
            if (bus.sum == r_point)
              w_next = ST_WIN;
            else if (w_sum32 == NATURAL_7 || w_limit)
              w_next = ST_LOSE;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (bus.new_game) begin
          w_next = ST_COME_OUT;
          w_clr  = 1'b1;
        end
      end
      default: w_next = ST_COME_OUT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_COME_OUT;
      r_point <= '0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_bad   <= w_bad;
      if (w_clr)
        r_point <= '0;
      else if (w_set_point)
        r_point <= bus.sum;
    end
  end

  craps_sat_counter #(.W(ROLL_W)) u_rolls (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .i_inc (w_roll_inc),
    .o_cnt (w_rolls)
  );

  assign bus.state   = r_state;
  assign bus.point   = r_point;
  assign bus.rolls   = w_rolls;
  assign bus.bad_sum = r_bad;

`ifdef CRAPS_STATS_EN
  logic w_win_evt, w_loss_evt;

  assign w_win_evt  = (w_next == ST_WIN)  && (r_state != ST_WIN);
  assign w_loss_evt = (w_next == ST_LOSE) && (r_state != ST_LOSE);

  craps_sat_counter #(.W(CNT_W)) u_win_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (1'b0),
    .i_inc (w_win_evt),
    .o_cnt (bus.win_cnt)
  );

  craps_sat_counter #(.W(CNT_W)) u_loss_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (1'b0),
    .i_inc (w_loss_evt),
    .o_cnt (bus.loss_cnt)
  );
`else
  assign bus.win_cnt  = '0;
  assign bus.loss_cnt = '0;
`endif
endmodule

// File: tb/tb_craps_round_ctrl.sv
// Directed-vector bench for craps_round_ctrl (limit-3/2-bit-stats and unlimited builds).
module tb_craps_round_ctrl;
`ifdef CRAPS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  craps_round_ctrl_if #(.SUM_W(4), .ROLL_W(6), .CNT_W(2)) ifa ();
  craps_round_ctrl_if #(.SUM_W(4), .ROLL_W(6), .CNT_W(8)) ifb ();

  craps_round_ctrl #(.SUM_W(4), .ROLL_W(6), .MAX_ROLLS(3), .CNT_W(2)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa)
  );

  craps_round_ctrl #(.SUM_W(4), .ROLL_W(6), .MAX_ROLLS(0), .CNT_W(8)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb)
  );

  typedef struct {
    logic       rst_n;
    logic       rv;
    logic [3:0] sum;
    logic       ng;
    logic [1:0] st;
    logic [3:0] pt;
    logic [5:0] rl;
    logic       bad;
    logic [1:0] w;
    logic [1:0] l;
  } vec_t;

  vec_t tv[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic void add(input logic rst_n, input logic rv, input logic [3:0] sum,
                              input logic ng, input logic [1:0] st, input logic [3:0] pt,
                              input logic [5:0] rl, input logic bad, input logic [1:0] w,
                              input logic [1:0] l);
    vec_t v;
    v.rst_n = rst_n; v.rv = rv; v.sum = sum; v.ng = ng;
    v.st = st; v.pt = pt; v.rl = rl; v.bad = bad; v.w = w; v.l = l;
    tv.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0d: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic step_b(input logic rv, input logic [3:0] sum, input logic ng);
    @(negedge clk);
    ifb.roll_valid = rv;
    ifb.sum        = sum;
    ifb.new_game   = ng;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string nm, input logic [1:0] st, input logic [3:0] pt,
                       input logic [5:0] rl, input logic [7:0] w);
    n_vec++;
    chk({nm, ".state"}, n_vec, 32'(ifb.state), 32'(st));
    chk({nm, ".point"}, n_vec, 32'(ifb.point), 32'(pt));
    chk({nm, ".rolls"}, n_vec, 32'(ifb.rolls), 32'(rl));
    chk({nm, ".win_cnt"}, n_vec, 32'(ifb.win_cnt), STATS ? 32'(w) : 32'd0);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.roll_valid = 1'b0; ifa.sum = '0; ifa.new_game = 1'b0;
    ifb.roll_valid = 1'b0; ifb.sum = '0; ifb.new_game = 1'b0;

    //  rst rv sum ng | st  pt rl bad w  l
    add(0, 0,  0, 0,   0,  0, 0, 0,  0, 0);  // reset
    add(1, 0,  0, 0,   0,  0, 0, 0,  0, 0);
    add(1, 1,  7, 0,   2,  0, 1, 0,  1, 0);  // natural 7
    add(1, 1,  7, 0,   2,  0, 1, 0,  1, 0);  // ignored in WIN
    add(1, 0,  0, 1,   0,  0, 0, 0,  1, 0);  // ack
    add(1, 1,  6, 0,   1,  6, 1, 0,  1, 0);  // point 6
    add(1, 1,  4, 0,   1,  6, 2, 0,  1, 0);
    add(1, 1,  9, 0,   1,  6, 3, 0,  1, 0);
    add(1, 1,  6, 0,   2,  6, 4, 0,  2, 0);  // make point on limit roll
    add(1, 0,  0, 1,   0,  0, 0, 0,  2, 0);
    add(1, 1,  5, 0,   1,  5, 1, 0,  2, 0);
    add(1, 1,  7, 0,   3,  5, 2, 0,  2, 1);  // seven-out
    add(1, 1,  7, 0,   3,  5, 2, 0,  2, 1);  // ignored in LOSE
    add(1, 1, 13, 0,   3,  5, 2, 0,  2, 1);  // illegal ignored, no bad_sum
    add(1, 1, 11, 1,   0,  0, 0, 0,  2, 1);  // new_game beats roll
    add(1, 0,  0, 0,   0,  0, 0, 0,  2, 1);
    add(1, 1, 13, 0,   0,  0, 0, 1,  2, 1);  // bad sum
    add(1, 0,  0, 0,   0,  0, 0, 0,  2, 1);
    add(1, 1,  1, 0,   0,  0, 0, 1,  2, 1);
    add(1, 1,  0, 0,   0,  0, 0, 1,  2, 1);
    add(1, 1,  3, 0,   3,  0, 1, 0,  2, 2);  // craps 3
    add(1, 0,  0, 1,   0,  0, 0, 0,  2, 2);
    add(1, 1,  8, 0,   1,  8, 1, 0,  2, 2);
    add(1, 1,  4, 0,   1,  8, 2, 0,  2, 2);
    add(1, 1,  5, 0,   1,  8, 3, 0,  2, 2);
    add(1, 1, 15, 0,   1,  8, 3, 1,  2, 2);  // bad sum in POINT
    add(1, 1,  6, 0,   3,  8, 4, 0,  2, 3);  // roll-limit LOSE
    add(1, 0,  0, 1,   0,  0, 0, 0,  2, 3);
    add(1, 1, 12, 0,   3,  0, 1, 0,  2, 3);  // loss_cnt saturated
    add(1, 0,  0, 1,   0,  0, 0, 0,  2, 3);
    add(1, 1,  4, 0,   1,  4, 1, 0,  2, 3);
    add(0, 1,  4, 0,   0,  0, 0, 0,  0, 0);  // mid-round reset
    add(1, 1,  2, 0,   3,  0, 1, 0,  0, 1);
    add(1, 0,  0, 1,   0,  0, 0, 0,  0, 1);
    add(1, 1, 11, 0,   2,  0, 1, 0,  1, 1);
    add(1, 0,  0, 1,   0,  0, 0, 0,  1, 1);
    add(1, 1, 11, 0,   2,  0, 1, 0,  2, 1);
    add(1, 0,  0, 1,   0,  0, 0, 0,  2, 1);
    add(1, 1,  7, 0,   2,  0, 1, 0,  3, 1);
    add(1, 0,  0, 1,   0,  0, 0, 0,  3, 1);
    add(1, 1, 11, 0,   2,  0, 1, 0,  3, 1);  // win_cnt saturated
    add(1, 0,  0, 1,   0,  0, 0, 0,  3, 1);
    add(1, 1, 11, 0,   2,  0, 1, 0,  3, 1);
    add(1, 0,  0, 1,   0,  0, 0, 0,  3, 1);
    add(1, 1,  9, 0,   1,  9, 1, 0,  3, 1);
    add(1, 0,  0, 1,   1,  9, 1, 0,  3, 1);  // new_game ignored in POINT
    add(1, 1,  9, 0,   2,  9, 2, 0,  3, 1);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst_a          = tv[i].rst_n;
      ifa.roll_valid = tv[i].rv;
      ifa.sum        = tv[i].sum;
      ifa.new_game   = tv[i].ng;
      @(posedge clk);
      #1;
      n_vec++;
      chk("state",    i, 32'(ifa.state),    32'(tv[i].st));
      chk("point",    i, 32'(ifa.point),    32'(tv[i].pt));
      chk("rolls",    i, 32'(ifa.rolls),    32'(tv[i].rl));
      chk("bad_sum",  i, 32'(ifa.bad_sum),  32'(tv[i].bad));
      chk("win_cnt",  i, 32'(ifa.win_cnt),  STATS ? 32'(tv[i].w) : 32'd0);
      chk("loss_cnt", i, 32'(ifa.loss_cnt), STATS ? 32'(tv[i].l) : 32'd0);
    end

    // Unlimited build: long point phase, rolls counter saturates at 63.
    step_b(1'b0, 4'd0, 1'b0);
    chk_b("b_reset", 2'd0, 4'd0, 6'd0, 8'd0);
    rst_b = 1'b1;
    step_b(1'b1, 4'd4, 1'b0);
    chk_b("b_point", 2'd1, 4'd4, 6'd1, 8'd0);
    for (int k = 1; k <= 70; k++) begin
      step_b(1'b1, 4'd5, 1'b0);
      if (k == 6)
        chk_b("b_nolimit", 2'd1, 4'd4, 6'd7, 8'd0);
    end
    chk_b("b_sat", 2'd1, 4'd4, 6'd63, 8'd0);
    step_b(1'b1, 4'd4, 1'b0);
    chk_b("b_win", 2'd2, 4'd4, 6'd63, 8'd1);
    step_b(1'b0, 4'd0, 1'b1);
    chk_b("b_ack", 2'd0, 4'd0, 6'd0, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/craps_round_ctrl.md
Name: craps_round_ctrl

Overview:
Clocked, parametrised successor to the team's craps outcome logic. Consumes validated dice-sum strobes and latches the point internally, where the earlier block relied on an external point input. It holds the WIN/LOSE verdict until the host acknowledges it and can enforce a roll limit in the point phase. It sits between the dice-sum generator and the display/score path.

Parameters:
SUM_W, 4, width of the sum input and point output (must be >= 4)
ROLL_W, 6, width of the point-phase roll counter
MAX_ROLLS, 0, point-phase roll limit; 0 = unlimited, N>0 = forced LOSE on the Nth non-deciding roll
CNT_W, 8, width of the win/loss statistics counters

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low
roll_valid  in  1  one-cycle strobe; sum is valid this cycle
sum  in  SUM_W  dice total
new_game  in  1  acknowledge verdict and start a new round
state  out  2  00 COME_OUT, 01 POINT, 10 WIN, 11 LOSE
point  out  SUM_W  latched point; 0 when no point is set
rolls  out  ROLL_W  rolls taken in the current round (come-out roll included)
bad_sum  out  1  one-cycle pulse: illegal sum rejected
win_cnt  out  CNT_W  total wins (only with the feature enabled)
loss_cnt  out  CNT_W  total losses (only with the feature enabled)

Behaviour:
- Reset (reset==0 at a clk edge) dominates all other inputs:
  - state=COME_OUT, point=0, rolls=0, bad_sum=0
  - win_cnt and loss_cnt also clear to 0
  - Reset mid-round abandons the round; no statistics update.
- All outputs are registered. The effect of a roll sampled at edge k is visible after edge k (1-cycle latency).
- Legal sum range is 2..12 inclusive.
  - A roll_valid with an out-of-range sum pulses bad_sum for 1 cycle.
  - It changes neither state, point nor rolls.
- COME_OUT, on a legal roll (rolls increments):
  - 7 or 11 -> WIN
  - 2, 3 or 12 -> LOSE
  - otherwise point<=sum, next state POINT
- POINT, on a legal roll (rolls increments; saturates at all-ones):
  - sum==point -> WIN (takes priority over 7)
  - sum==7 -> LOSE
  - otherwise stay in POINT
  - If MAX_ROLLS>0 and the number of point-phase rolls (rolls-1 after the increment) reaches MAX_ROLLS without a decision -> LOSE.
- WIN/LOSE:
  - Hold indefinitely; point and rolls stay frozen for display.
  - roll_valid is ignored with no bad_sum, even for an illegal sum.
  - new_game -> COME_OUT with point=0 and rolls=0 on the next edge.
- new_game outside WIN/LOSE is ignored.
- new_game and roll_valid in the same cycle while in WIN/LOSE: new_game wins and the roll is discarded, not applied to the new round.
- State encoding is fixed (00/01/10/11). The unreachable default falls back to COME_OUT.

Optional Feature:
CRAPS_STATS_EN
- Defined:
  - win_cnt increments once on each transition into WIN.
  - loss_cnt increments once on each transition into LOSE, the roll-limit LOSE included.
  - Both saturate at all-ones and never wrap.
- Undefined: win_cnt and loss_cnt are tied to 0 and no counter flops are synthesised.

Decomposition:
- Package craps_pkg:
  - state enum with the fixed encoding
  - constants SUM_MIN=2, SUM_MAX=12, NATURAL_7=7, NATURAL_11=11, CRAPS_2=2, CRAPS_3=3, CRAPS_12=12
- One sub-module, craps_sat_counter (parametrised width, sync clear, increment enable, saturate). It is instantiated twice under CRAPS_STATS_EN and reusable for rolls.

Test Plan:
- Come-out roll 7 -> state=10 one cycle later, rolls=1, win_cnt=1; new_game -> state=00, rolls=0, point=0.
- Come-out 6, then 4, 9, then 6 -> point=6 after the first roll, state 01 throughout the middle rolls, final state=10, rolls=4.
- Come-out 5, then 7 -> LOSE; roll 7 again while in LOSE -> no change; new_game plus a roll_valid of 11 in the same cycle -> state=00 with rolls=0, not WIN.
- MAX_ROLLS=3: come-out 8, then 4, 5, 6 -> state=11 after the third point-phase roll, loss_cnt=1.
- sum=13 or 1 in COME_OUT -> bad_sum pulses 1 cycle, state=00, rolls=0; come-out 3 -> LOSE.
- Mid-POINT reset low for 1 cycle -> all outputs zero with state=00; CNT_W=2 with 5 forced wins -> win_cnt stays 3.
